// File: rtl/isa_pkg.sv
// WISC ISA constants shared by decode, control and the constant loader.
// Also holds the constant-loader sequencing state type.
package isa_pkg;

    localparam logic [4:0] LBI_OP  = 5'b11000;
    localparam logic [4:0] SLBI_OP = 5'b10010;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_LBI  = 2'd1,
        EMIT_SLBI = 2'd2
    } cl_state_t;

    function automatic logic [15:0] enc_ri(
        input logic [4:0] op,
        input logic [2:0] rd,
        input logic [7:0] imm
    );
        return {op, rd, imm};
    endfunction

endpackage

// File: rtl/imm8_fit_check.sv
// Reports whether a 16-bit value survives a round trip through a
// sign-extended 8-bit immediate.
module imm8_fit_check (
    input  logic [15:0] value,
    output logic        fits
);

    assign fits = (&value[15:7]) | ~(|value[15:7]);

endmodule

// File: rtl/const_loader.sv
// Turns a 16-bit constant into the shortest LBI / LBI+SLBI sequence
// that rebuilds it in the destination register.
module const_loader
    import isa_pkg::*;
#(
    parameter logic [4:0] LBI_OP    = isa_pkg::LBI_OP,
    parameter logic [4:0] SLBI_OP   = isa_pkg::SLBI_OP,
    parameter bit         FORCE_TWO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic [2:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic        out_last,
    output logic        err_busy_drop
);

    cl_state_t   state;
    logic [15:0] value_q;
    logic [2:0]  rd_q;
    logic        fits_q;
    logic        fits_raw;
    logic        fits_now;
    logic        req_changed;

    imm8_fit_check u_fit (
        .value (in_value),
        .fits  (fits_raw)
    );

    assign fits_now    = fits_raw & ~FORCE_TWO;
    assign req_changed = (in_value != value_q) || (in_rd != rd_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            value_q       <= 16'h0000;
            rd_q          <= 3'd0;
            fits_q        <= 1'b0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_instr     <= 16'h0000;
            out_last      <= 1'b0;
            err_busy_drop <= 1'b0;
        end else begin
            if (in_valid && !in_ready && req_changed)
                err_busy_drop <= 1'b1;

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        value_q   <= in_value;
                        rd_q      <= in_rd;
                        fits_q    <= fits_now;
                        state     <= EMIT_LBI;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_last  <= fits_now;
                        out_instr <= enc_ri(LBI_OP, in_rd,
                            fits_now ? in_value[7:0] : in_value[15:8]);
                    end
                end
                EMIT_LBI: begin
                    if (out_ready) begin
                        if (fits_q) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            // high byte already placed; shift it up, OR in low
                            state     <= EMIT_SLBI;
                            out_last  <= 1'b1;
                            out_instr <= enc_ri(SLBI_OP, rd_q,
                                value_q[7:0]);
                        end
                    end
                end
                EMIT_SLBI: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_const_loader.sv
// Scoreboard bench for const_loader: default build plus a FORCE_TWO build.
module tb_const_loader;

    localparam logic [4:0] OP_L = 5'b11000;
    localparam logic [4:0] OP_S = 5'b10010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic        in_ready0, in_ready1;
    logic [15:0] in_value0 = '0, in_value1 = '0;
    logic [2:0]  in_rd0 = '0, in_rd1 = '0;
    logic        out_valid0, out_valid1;
    logic        out_ready0 = 1'b1, out_ready1 = 1'b1;
    logic [15:0] out_instr0, out_instr1;
    logic        out_last0, out_last1;
    logic        err0, err1;

    int checks = 0;
    int errors = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];

    always #5 clk = ~clk;

    const_loader dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_value(in_value0), .in_rd(in_rd0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_instr(out_instr0), .out_last(out_last0),
        .err_busy_drop(err0)
    );

    const_loader #(.FORCE_TWO(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_value(in_value1), .in_rd(in_rd1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_instr(out_instr1), .out_last(out_last1),
        .err_busy_drop(err1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Fits when the value is representable as signed 8-bit.
    function automatic bit two_needed(input logic [15:0] v, input bit force2);
        int s;
        s = int'($signed(v));
        return force2 || s < -128 || s > 127;
    endfunction

    task automatic push_exp(input int sel, input logic [15:0] v,
                            input logic [2:0] r);
        bit two;
        logic [16:0] a, b;
        two = two_needed(v, sel == 1);
        a = two ? {1'b0, OP_L, r, v[15:8]} : {1'b1, OP_L, r, v[7:0]};
        b = {1'b1, OP_S, r, v[7:0]};
        if (sel == 0) begin
            q0.push_back(a);
            if (two) q0.push_back(b);
        end else begin
            q1.push_back(a);
            if (two) q1.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && out_valid0 && out_ready0) begin
            if (q0.size() == 0) check("spurious0", q0.size(), 1);
            else begin
                e = q0.pop_front();
                check("instr0", out_instr0, e[15:0]);
                check("last0", out_last0, e[16]);
            end
        end
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) check("spurious1", q1.size(), 1);
            else begin
                e = q1.pop_front();
                check("instr1", out_instr1, e[15:0]);
                check("last1", out_last1, e[16]);
            end
        end
    end

    task automatic send(input int sel, input logic [15:0] v,
                        input logic [2:0] r);
        int n = 0;
        while (((sel == 0) ? !in_ready0 : !in_ready1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rdy_wait", (sel == 0) ? in_ready0 : in_ready1, 1);
        push_exp(sel, v, r);
        if (sel == 0) begin
            in_valid0 = 1'b1; in_value0 = v; in_rd0 = r;
        end else begin
            in_valid1 = 1'b1; in_value1 = v; in_rd1 = r;
        end
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        check("lat_valid", (sel == 0) ? out_valid0 : out_valid1, 1);
        check("busy_rdy", (sel == 0) ? in_ready0 : in_ready1, 0);
    endtask

    task automatic drain(input int sel);
        int n = 0;
        while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", (sel == 0) ? q0.size() : q1.size(), 0);
        check("idle_rdy", (sel == 0) ? in_ready0 : in_ready1, 1);
        check("idle_val", (sel == 0) ? out_valid0 : out_valid1, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rdy", in_ready0, 1);
        check("rst_val", out_valid0, 0);
        check("rst_instr", out_instr0, 16'h0000);
        check("rst_last", out_last0, 0);
        check("rst_err", err0, 0);

        send(0, 16'h0005, 3'd3);
        check("c305", out_instr0, 16'hC305);
        drain(0);

        send(0, 16'h007F, 3'd5); drain(0);
        send(0, 16'hFF80, 3'd1);
        check("c180", out_instr0, 16'hC180);
        drain(0);
        send(0, 16'hFF7F, 3'd1); drain(0);
        send(0, 16'h0080, 3'd2);
        check("c200", out_instr0, 16'hC200);
        drain(0);
        send(0, 16'h0000, 3'd6); drain(0);
        for (int i = 0; i < 6; i++) begin
            send(0, 16'($urandom), 3'($urandom));
            drain(0);
        end

        // backpressure: both instructions held for three cycles
        out_ready0 = 1'b0;
        send(0, 16'h1234, 3'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_lbi", out_instr0, 16'hC712);
            check("hold_lbi_last", out_last0, 0);
            check("hold_rdy", in_ready0, 0);
        end
        @(posedge clk); #1 out_ready0 = 1'b1;
        @(posedge clk); #1 out_ready0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_slbi", out_instr0, 16'h9734);
            check("hold_slbi_last", out_last0, 1);
            check("hold_rdy2", in_ready0, 0);
        end
        @(posedge clk); #1 out_ready0 = 1'b1;
        drain(0);

        send(1, 16'h0005, 3'd0);
        check("c000", out_instr1, 16'hC000);
        drain(1);

        // protocol violation, then reset while SLBI is pending
        out_ready0 = 1'b0;
        send(0, 16'h0080, 3'd2);
        in_valid0 = 1'b1; in_value0 = 16'h5555; in_rd0 = 3'd2;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        check("err_set", err0, 1);
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
        check("slbi_pend", out_instr0, 16'h9280);
        check("err_sticky", err0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete();
        check("mid_rst_val", out_valid0, 0);
        check("mid_rst_rdy", in_ready0, 1);
        check("mid_rst_err", err0, 0);
        out_ready0 = 1'b1;
        send(0, 16'h0001, 3'd4);
        check("c401", out_instr0, 16'hC401);
        drain(0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
